status_flag_unit: RTL and testbench

Producer side of the condition-evaluation interface. Computes the ARM NZCV flags from the EX-stage ALU result and writes them into the architectural status register. Provides two 4-bit status words for the condition checker:
- the committed register value;
- a forwarded value that already includes an update still in flight.

Both words use the fixed packing {Z,C,N,V}. The checker consumes this exact order; it must not change.

---
 rtl/status_flag_unit_pkg.sv | 17 +
 rtl/status_flag_unit_flag_compute.sv | 50 +++++
 rtl/status_flag_unit.sv | 70 +++++++
 tb/tb_status_flag_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/status_flag_unit_pkg.sv
// Shared definitions for the NZCV status producer and the condition checker.
// Flag words are always packed {Z,C,N,V}.
package status_flag_unit_pkg;

  localparam logic [1:0] OPC_LOGIC = 2'b00;
  localparam logic [1:0] OPC_ADD   = 2'b01;
  localparam logic [1:0] OPC_SUB   = 2'b10;
  localparam logic [1:0] OPC_NZ    = 2'b11;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/status_flag_unit_flag_compute.sv
// Combinational NZCV derivation from the EX-stage ALU result.
// Bits an op class does not define are carried over from old_flags.
module status_flag_unit_flag_compute
  import status_flag_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        op_class,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry_out,
  input  logic              shifter_carry,
  input  flags_t            old_flags,
  output flags_t            new_flags
);

  localparam int MSB = DATA_W - 1;

  logic a_msb, b_msb, r_msb;
  assign a_msb = alu_a[MSB];
  assign b_msb = alu_b[MSB];
  assign r_msb = alu_result[MSB];

  // Only the sign bits of the operands influence overflow.
  logic unused_operand_bits;
  assign unused_operand_bits = ^{alu_a[MSB-1:0], alu_b[MSB-1:0]};

  always_comb begin
    new_flags         = old_flags;
    new_flags[FLAG_N] = r_msb;
    new_flags[FLAG_Z] = (alu_result == '0);
    case (op_class)
      OPC_ADD: begin
        new_flags[FLAG_C] = alu_carry_out;
        new_flags[FLAG_V] = (a_msb == b_msb) & (r_msb != a_msb);
      end
      OPC_SUB: begin
        new_flags[FLAG_C] = alu_carry_out;
        new_flags[FLAG_V] = (a_msb != b_msb) & (r_msb != a_msb);
      end
      OPC_LOGIC: begin
        new_flags[FLAG_C] = shifter_carry;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/status_flag_unit.sv
// NZCV producer: one pending stage P ahead of the committed status register,
// with a forwarded view so the condition checker sees in-flight updates.
module status_flag_unit
  import status_flag_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              s_bit,
  input  logic [1:0]        op_class,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry_out,
  input  logic              shifter_carry,
  input  logic              stall,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [3:0]        wr_flags,
  output logic [3:0]        status,
  output logic [3:0]        status_fwd,
  output logic              pend_valid
);

  flags_t pend_flags;
  flags_t alu_flags;
  flags_t new_flags;
  logic   cap;

  assign status_fwd = pend_valid ? pend_flags : status;

  // Preserved bits must see an update still sitting in P, hence status_fwd.
  status_flag_unit_flag_compute #(
    .DATA_W (DATA_W)
  ) u_flag_compute (
    .op_class      (op_class),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_result    (alu_result),
    .alu_carry_out (alu_carry_out),
    .shifter_carry (shifter_carry),
    .old_flags     (status_fwd),
    .new_flags     (alu_flags)
  );

  assign new_flags = wr_en ? wr_flags : alu_flags;
  assign cap       = ~stall & ~flush & ((in_valid & s_bit) | wr_en);

  // P is older than EX, so it commits regardless of stall/flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status     <= 4'b0000;
      pend_flags <= 4'b0000;
      pend_valid <= 1'b0;
    end else begin
      if (pend_valid) begin
        status <= pend_flags;
      end
      if (cap) begin
        pend_valid <= 1'b1;
        pend_flags <= new_flags;
      end else begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_status_flag_unit.sv
// Scoreboard bench for status_flag_unit: directed cases plus random traffic
// against an update-history reference model.
module tb_status_flag_unit;
  import status_flag_unit_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, s_bit, alu_carry_out, shifter_carry, stall, flush, wr_en;
  logic [1:0]    op_class;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [3:0]    wr_flags, status, status_fwd;
  logic          pend_valid;

  status_flag_unit #(.DATA_W(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .s_bit         (s_bit),
    .op_class      (op_class),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_result    (alu_result),
    .alu_carry_out (alu_carry_out),
    .shifter_carry (shifter_carry),
    .stall         (stall),
    .flush         (flush),
    .wr_en         (wr_en),
    .wr_flags      (wr_flags),
    .status        (status),
    .status_fwd    (status_fwd),
    .pend_valid    (pend_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic          iv, s, st, fl, we;
    logic [1:0]    op;
    logic [DW-1:0] a, b, r;
    logic          c, sc;
    logic [3:0]    wf;
  } stim_t;

  // Reference: a history of captured updates tagged with the edge that took them.
  typedef struct {
    int         e;
    logic [3:0] f;
  } upd_t;
  upd_t       hist[$];
  int         edge_n = 0;
  logic [8:0] expq[$];

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Committed value: newest update captured at least one edge ago.
  function automatic logic [3:0] m_status();
    logic [3:0] v = 4'b0000;
    foreach (hist[i]) if (hist[i].e <= edge_n - 1) v = hist[i].f;
    return v;
  endfunction

  function automatic logic m_pv();
    return (hist.size() > 0) && (hist[hist.size()-1].e == edge_n);
  endfunction

  function automatic logic [3:0] m_fwd();
    return m_pv() ? hist[hist.size()-1].f : m_status();
  endfunction

  // Flags from arithmetic meaning: V is set when the exact signed result
  // does not fit in the DW-bit result.
  function automatic logic [3:0] ref_flags(input stim_t x, input logic [3:0] prev);
    longint sa = longint'($signed(x.a));
    longint sb = longint'($signed(x.b));
    longint sr = longint'($signed(x.r));
    logic z = (x.r == 0);
    logic n = x.r[DW-1];
    logic c = prev[2];
    logic v = prev[0];
    case (x.op)
      OPC_ADD:   begin c = x.c;  v = ((sa + sb) != sr); end
      OPC_SUB:   begin c = x.c;  v = ((sa - sb) != sr); end
      OPC_LOGIC: begin c = x.sc; end
      default:   begin end
    endcase
    return {z, c, n, v};
  endfunction

  function automatic stim_t idle();
    stim_t x = '0;
    return x;
  endfunction

  function automatic stim_t alu(input logic [1:0] op, input logic [DW-1:0] a, b, r,
                                input logic c, sc);
    stim_t x = '0;
    x.iv = 1'b1; x.s = 1'b1; x.op = op;
    x.a = a; x.b = b; x.r = r; x.c = c; x.sc = sc;
    return x;
  endfunction

  function automatic stim_t rand_stim();
    stim_t x = '0;
    x.op = 2'($urandom_range(0, 3));
    x.a  = $urandom;
    x.b  = ($urandom_range(0, 3) == 0) ? x.a : $urandom;
    if ($urandom_range(0, 7) == 0) x.a = 32'h7FFF_FFFF;
    if ($urandom_range(0, 7) == 0) x.b = 32'h8000_0000;
    case (x.op)
      OPC_ADD:   {x.c, x.r} = {1'b0, x.a} + {1'b0, x.b};
      OPC_SUB:   begin x.r = x.a - x.b; x.c = (x.a >= x.b); end
      OPC_LOGIC: begin x.r = x.a & x.b; x.sc = 1'($urandom); end
      default:   x.r = x.a ^ x.b;
    endcase
    x.iv = ($urandom_range(0, 3) != 0);
    x.s  = ($urandom_range(0, 3) != 0);
    x.st = ($urandom_range(0, 5) == 0);
    x.fl = ($urandom_range(0, 5) == 0);
    x.we = ($urandom_range(0, 7) == 0);
    x.wf = 4'($urandom);
    return x;
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input stim_t x);
    logic [3:0] pf, nf;
    logic       cap;
    in_valid = x.iv; s_bit = x.s; stall = x.st; flush = x.fl; wr_en = x.we;
    op_class = x.op; alu_a = x.a; alu_b = x.b; alu_result = x.r;
    alu_carry_out = x.c; shifter_carry = x.sc; wr_flags = x.wf;
    @(posedge clk);
    pf  = m_fwd();
    cap = !x.st && !x.fl && ((x.iv && x.s) || x.we);
    nf  = x.we ? x.wf : ref_flags(x, pf);
    edge_n++;
    if (cap) hist.push_back('{edge_n, nf});
    while (hist.size() > 3) void'(hist.pop_front());
    expq.push_back({m_status(), m_fwd(), m_pv()});
    @(negedge clk);
  endtask

  initial begin : monitor
    logic [8:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("scoreboard{status,fwd,pv}", {status, status_fwd, pend_valid}, e);
      end
    end
  end

  initial begin : stimulus
    stim_t x;
    rst = 1'b1;
    in_valid = 0; s_bit = 0; stall = 0; flush = 0; wr_en = 0; op_class = 0;
    alu_a = 0; alu_b = 0; alu_result = 0; alu_carry_out = 0; shifter_carry = 0;
    wr_flags = 0;
    #1;
    chk("reset_state", {status, status_fwd, pend_valid}, 9'b0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset with an update pending
    cycle(alu(OPC_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0));
    #2;
    rst = 1'b1;
    hist.delete();
    #1;
    chk("reset_async_status", {5'b0, status}, 9'b0);
    chk("reset_async_pv", {8'b0, pend_valid}, 9'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle(idle());
    cycle(idle());
    chk("reset_after_idle", {5'b0, status}, 9'b0);

    // SUB equal
    cycle(alu(OPC_SUB, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0));
    chk("sub_eq_fwd", {5'b0, status_fwd}, {5'b0, 4'b1100});
    cycle(idle());
    chk("sub_eq_status", {5'b0, status}, {5'b0, 4'b1100});

    // ADD overflow, SUB, LOGIC back-to-back
    cycle(alu(OPC_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0));
    chk("add_ovf_fwd", {5'b0, status_fwd}, {5'b0, 4'b0011});
    cycle(alu(OPC_SUB, 32'd3, 32'd1, 32'd2, 1'b1, 1'b0));
    chk("b2b_sub_fwd", {5'b0, status_fwd}, {5'b0, 4'b0100});
    chk("b2b_add_status", {5'b0, status}, {5'b0, 4'b0011});
    cycle(alu(OPC_LOGIC, 32'h0000_00F0, 32'h0000_000F, 32'd0, 1'b1, 1'b0));
    chk("logic_keepv_fwd", {5'b0, status_fwd}, {5'b0, 4'b1000});
    chk("b2b_sub_status", {5'b0, status}, {5'b0, 4'b0100});
    cycle(idle());
    chk("logic_keepv_status", {5'b0, status}, {5'b0, 4'b1000});

    // Gating: flush, stall, s_bit=0
    x = alu(OPC_SUB, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0); x.fl = 1'b1;
    cycle(x);
    chk("gate_flush", {status, status_fwd, pend_valid}, {4'b1000, 4'b1000, 1'b0});
    x.fl = 1'b0; x.st = 1'b1;
    cycle(x);
    chk("gate_stall", {status, status_fwd, pend_valid}, {4'b1000, 4'b1000, 1'b0});
    x.st = 1'b0; x.s = 1'b0;
    cycle(x);
    chk("gate_nos", {status, status_fwd, pend_valid}, {4'b1000, 4'b1000, 1'b0});

    // Explicit write beats a simultaneous ALU update
    x = alu(OPC_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    x.we = 1'b1; x.wf = 4'b0101;
    cycle(x);
    chk("wr_prio_fwd", {5'b0, status_fwd}, {5'b0, 4'b0101});
    cycle(idle());
    chk("wr_prio_status", {5'b0, status}, {5'b0, 4'b0101});

    repeat (500) cycle(rand_stim());
    cycle(idle());
    cycle(idle());
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 9'(expq.size()), 9'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
